// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with claim scoreboard.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned ADDR_W_DEF   = 3;
    localparam int unsigned NUM_REGS_DEF = 2 ** ADDR_W_DEF;

    // Register address at the default geometry
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/busy_tracker.sv
// Per-register busy bits plus a running count of claimed registers.
// A set and a clear to the same register in one cycle leave the bit set.
module busy_tracker
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_en,
    input  logic [ADDR_W-1:0]       set_addr,
    input  logic                    clr_en,
    input  logic [ADDR_W-1:0]       clr_addr,
    output logic [(2**ADDR_W)-1:0]  busy,
    output logic [ADDR_W:0]         busy_cnt
);

    logic [(2**ADDR_W)-1:0] busy_q, busy_d;
    logic [ADDR_W:0]        cnt_q, cnt_d;
    logic                   rise, fall;

    // Next busy vector and count; set is applied after clear so it wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;

        rise  = set_en && !busy_q[set_addr];
        fall  = clr_en && busy_q[clr_addr] && !(set_en && (set_addr == clr_addr));
        cnt_d = cnt_q + {{ADDR_W{1'b0}}, rise} - {{ADDR_W{1'b0}}, fall};
    end

    // Busy state register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read, one-write register file with write-to-read bypass and a
// destination-claim scoreboard. Define REGFILE_REG0_ZERO_EN to hardwire
// register 0 to zero (reads 0, writes ignored, claims never mark it busy).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              claim_ok,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

`ifdef REGFILE_REG0_ZERO_EN
    localparam bit Reg0Zero = 1'b1;
`else
    localparam bit Reg0Zero = 1'b0;
`endif

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_eff;
    logic                wr_hit1, wr_hit2, wr_hit_claim;
    logic                set_en;

    // Decode write effect, bypass hits, claim acceptance and read ports
    always_comb begin
        wr_eff       = wr_en && !(Reg0Zero && (wr_addr == '0));
        wr_hit1      = wr_eff && (wr_addr == rd_addr1);
        wr_hit2      = wr_eff && (wr_addr == rd_addr2);
        wr_hit_claim = wr_en && (wr_addr == claim_addr);

        // Register 0 is never busy when hardwired, so this yields claim_en there
        claim_ok = claim_en && (!busy[claim_addr] || wr_hit_claim);
        set_en   = claim_ok && !(Reg0Zero && (claim_addr == '0));

        rd_data1 = wr_hit1 ? wr_data : regs_q[rd_addr1];
        rd_data2 = wr_hit2 ? wr_data : regs_q[rd_addr2];
        if (Reg0Zero && (rd_addr1 == '0)) rd_data1 = '0;
        if (Reg0Zero && (rd_addr2 == '0)) rd_data2 = '0;

        rd_busy1 = busy[rd_addr1] && !wr_hit1;
        rd_busy2 = busy[rd_addr2] && !wr_hit2;
    end

    // Register storage with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_eff) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    busy_tracker #(
        .ADDR_W (ADDR_W)
    ) u_busy_tracker (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_addr (claim_addr),
        .clr_en   (wr_eff),
        .clr_addr (wr_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard with a behavioural model.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;
`ifdef REGFILE_REG0_ZERO_EN
    localparam bit Z = 1'b1;
`else
    localparam bit Z = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, claim_addr;
    logic [DW-1:0] rd_data1, rd_data2, wr_data;
    logic          rd_busy1, rd_busy2, wr_en, claim_en, claim_ok;
    logic [AW:0]   busy_cnt;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];

    regfile_scoreboard #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_busy1   (rd_busy1),
        .rd_busy2   (rd_busy2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .claim_ok   (claim_ok),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit wen_eff();
        return wr_en && !(Z && wr_addr == 0);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (Z && a == 0) return '0;
        if (wen_eff() && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        return m_busy[a] && !(wen_eff() && wr_addr == a);
    endfunction

    function automatic bit exp_claim_ok();
        if (!claim_en) return 1'b0;
        if (Z && claim_addr == 0) return 1'b1;
        return !m_busy[claim_addr] || (wr_en && wr_addr == claim_addr);
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive(input bit we, input int wa, input int wd, input bit ce,
                         input int ca, input int r1, input int r2);
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = DW'(wd);
        claim_en   = ce;
        claim_addr = AW'(ca);
        rd_addr1   = AW'(r1);
        rd_addr2   = AW'(r2);
        #1;
    endtask

    // Advance one clock edge and update the model from the presented inputs
    task automatic tick();
        bit            ok  = exp_claim_ok();
        bit            we  = wen_eff();
        logic [AW-1:0] wa  = wr_addr;
        logic [DW-1:0] wd  = wr_data;
        logic [AW-1:0] ca  = claim_addr;
        @(posedge clk);
        if (we) begin
            m_regs[wa] = wd;
            if (!(ok && ca == wa)) m_busy[wa] = 1'b0;
        end
        if (ok && !(Z && ca == 0)) m_busy[ca] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 3, 5);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy_cnt !== 0) begin errors++;
            $display("FAIL reset_cnt: got %0d expected 0", busy_cnt); end
        checks++; if (rd_data1 !== 8'h00) begin errors++;
            $display("FAIL reset_data: got %h expected 00", rd_data1); end
        reset = 1'b0;
        model_reset();

        drive(1, 3, 'h5A, 1, 5, 3, 5);
        tick();
        drive(0, 0, 0, 0, 0, 3, 5);
        checks++; if (rd_data1 !== exp_rd(3)) begin errors++;
            $display("FAIL pre_reset_r3: got %h expected %h", rd_data1, exp_rd(3)); end
        checks++; if (rd_busy2 !== 1'b1) begin errors++;
            $display("FAIL pre_reset_busy5: got %b expected 1", rd_busy2); end
        checks++; if (busy_cnt !== 1) begin errors++;
            $display("FAIL pre_reset_cnt: got %0d expected 1", busy_cnt); end

        // Assert reset away from any edge: must take effect at once
        #2;
        reset = 1'b1;
        #1;
        checks++; if (rd_data1 !== 8'h00) begin errors++;
            $display("FAIL async_reset_r3: got %h expected 00", rd_data1); end
        checks++; if (rd_busy2 !== 1'b0) begin errors++;
            $display("FAIL async_reset_busy5: got %b expected 0", rd_busy2); end
        checks++; if (busy_cnt !== 0) begin errors++;
            $display("FAIL async_reset_cnt: got %0d expected 0", busy_cnt); end

        // Write and claim presented during reset are discarded
        drive(1, 3, 'h22, 1, 6, 3, 6);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 3, 6);
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (rd_data1 !== 8'h00 || rd_busy2 !== 1'b0 || busy_cnt !== 0) begin
            errors++;
            $display("FAIL reset_discard: got d=%h b=%b c=%0d expected d=00 b=0 c=0",
                     rd_data1, rd_busy2, busy_cnt);
        end
    endtask

    task automatic test_bypass();
        drive(1, 2, 'hC3, 0, 0, 2, 0);
        checks++; if (rd_data1 !== 8'hC3) begin errors++;
            $display("FAIL bypass_comb: got %h expected c3", rd_data1); end
        tick();
        drive(0, 0, 0, 0, 0, 2, 2);
        checks++; if (rd_data1 !== 8'hC3 || rd_data2 !== 8'hC3) begin errors++;
            $display("FAIL bypass_stored: got %h/%h expected c3/c3", rd_data1, rd_data2); end
        // Both read ports on the write address see the bypassed value
        drive(1, 1, 'h3C, 0, 0, 1, 1);
        checks++; if (rd_data1 !== 8'h3C || rd_data2 !== 8'h3C) begin errors++;
            $display("FAIL bypass_dual: got %h/%h expected 3c/3c", rd_data1, rd_data2); end
        tick();
    endtask

    task automatic test_claim_retry();
        drive(0, 0, 0, 1, 4, 4, 0);
        checks++; if (claim_ok !== 1'b1) begin errors++;
            $display("FAIL claim4_first: got %b expected 1", claim_ok); end
        tick();
        checks++; if (busy_cnt !== 1 || rd_busy1 !== 1'b1) begin errors++;
            $display("FAIL claim4_busy: got c=%0d b=%b expected c=1 b=1", busy_cnt, rd_busy1); end
        drive(0, 0, 0, 1, 4, 4, 0);
        checks++; if (claim_ok !== 1'b0) begin errors++;
            $display("FAIL claim4_again: got %b expected 0", claim_ok); end
        tick();
        checks++; if (busy_cnt !== 1) begin errors++;
            $display("FAIL claim4_cnt_hold: got %0d expected 1", busy_cnt); end
        drive(1, 4, 'h11, 0, 0, 4, 0);
        checks++; if (rd_busy1 !== 1'b0) begin errors++;
            $display("FAIL wb4_busy_mask: got %b expected 0", rd_busy1); end
        tick();
        drive(0, 0, 0, 0, 0, 4, 0);
        checks++; if (busy_cnt !== 0 || rd_busy1 !== 1'b0 || rd_data1 !== 8'h11) begin
            errors++;
            $display("FAIL wb4_clear: got c=%0d b=%b d=%h expected c=0 b=0 d=11",
                     busy_cnt, rd_busy1, rd_data1);
        end
    endtask

    task automatic test_claim_wins();
        drive(0, 0, 0, 1, 6, 6, 0);
        tick();
        checks++; if (busy_cnt !== 1) begin errors++;
            $display("FAIL claim6_cnt: got %0d expected 1", busy_cnt); end
        drive(1, 6, 'h7E, 1, 6, 6, 0);
        checks++; if (claim_ok !== 1'b1) begin errors++;
            $display("FAIL claim6_with_wb: got %b expected 1", claim_ok); end
        tick();
        drive(0, 0, 0, 0, 0, 6, 0);
        checks++; if (rd_busy1 !== 1'b1 || busy_cnt !== 1 || rd_data1 !== 8'h7E) begin
            errors++;
            $display("FAIL claim_wins: got b=%b c=%0d d=%h expected b=1 c=1 d=7e",
                     rd_busy1, busy_cnt, rd_data1);
        end
        drive(1, 6, 'h7E, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_claim_all();
        do_reset();
        for (int i = 0; i < NR; i++) begin
            drive(0, 0, 0, 1, i, 0, 0);
            checks++; if (claim_ok !== 1'b1) begin errors++;
                $display("FAIL claim_all_%0d: got %b expected 1", i, claim_ok); end
            tick();
        end
        checks++; if (busy_cnt !== (Z ? 7 : 8)) begin errors++;
            $display("FAIL claim_all_cnt: got %0d expected %0d", busy_cnt, Z ? 7 : 8); end
        drive(0, 0, 0, 1, 0, 0, 0);
        checks++; if (claim_ok !== Z) begin errors++;
            $display("FAIL claim_r0_again: got %b expected %b", claim_ok, Z); end
        tick();
        checks++; if (busy_cnt !== (Z ? 7 : 8)) begin errors++;
            $display("FAIL claim_all_cnt_hold: got %0d expected %0d", busy_cnt, Z ? 7 : 8); end
        do_reset();
    endtask

    task automatic test_reg0();
        drive(1, 0, 'hFF, 0, 0, 0, 0);
        checks++; if (rd_data1 !== (Z ? 8'h00 : 8'hFF)) begin errors++;
            $display("FAIL r0_comb: got %h expected %h", rd_data1, Z ? 8'h00 : 8'hFF); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (rd_data1 !== (Z ? 8'h00 : 8'hFF)) begin errors++;
            $display("FAIL r0_stored: got %h expected %h", rd_data1, Z ? 8'h00 : 8'hFF); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 4, $urandom_range(0, NR - 1), $urandom_range(0, 255),
                  $urandom_range(0, 9) < 6, $urandom_range(0, NR - 1),
                  $urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
            checks++; if (rd_data1 !== exp_rd(rd_addr1) || rd_data2 !== exp_rd(rd_addr2)) begin
                errors++;
                $display("FAIL rand_rd[%0d]: got %h/%h expected %h/%h", n, rd_data1, rd_data2,
                         exp_rd(rd_addr1), exp_rd(rd_addr2));
            end
            checks++; if (rd_busy1 !== exp_busy(rd_addr1) || rd_busy2 !== exp_busy(rd_addr2)) begin
                errors++;
                $display("FAIL rand_busy[%0d]: got %b/%b expected %b/%b", n, rd_busy1, rd_busy2,
                         exp_busy(rd_addr1), exp_busy(rd_addr2));
            end
            checks++; if (claim_ok !== exp_claim_ok()) begin errors++;
                $display("FAIL rand_claim_ok[%0d]: got %b expected %b", n, claim_ok,
                         exp_claim_ok()); end
            tick();
            checks++; if (int'(busy_cnt) != m_cnt()) begin errors++;
                $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, busy_cnt, m_cnt()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bypass();
        test_claim_retry();
        test_claim_wins();
        test_claim_all();
        test_reg0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning register address width; register count NUM_REGS = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports rd_addr1, rd_addr2  input  ADDR_W  read port addresses.
REQ-006 SHALL have ports rd_data1, rd_data2  output  DATA_W  read data, combinational.
REQ-007 SHALL have ports rd_busy1, rd_busy2  output  1  addressed register has a pending claim.
REQ-008 SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_W) and wr_data (input, DATA_W), the write-back port.
REQ-009 SHALL have ports claim_en (input, 1) and claim_addr (input, ADDR_W), the destination-claim request.
REQ-010 SHALL have port claim_ok  output  1  claim accepted this cycle.
REQ-011 SHALL have port busy_cnt  output  ADDR_W+1  number of registers currently claimed.

Function
REQ-012 SHALL write wr_data to register wr_addr on the clk edge when wr_en=1.
REQ-013 SHALL bypass: when wr_en=1 and wr_addr==rd_addrN, rd_dataN = wr_data in the same cycle; otherwise rd_dataN = stored value.
REQ-014 SHALL keep one busy bit per register; rd_busyN = busy[rd_addrN] AND NOT (wr_en AND wr_addr==rd_addrN).
REQ-015 SHALL drive claim_ok = claim_en AND (NOT busy[claim_addr] OR (wr_en AND wr_addr==claim_addr)).
REQ-016 SHALL set busy[claim_addr] on the edge when claim_ok=1; a rejected claim changes no state and must be retried by the requester.
REQ-017 SHALL clear busy[wr_addr] on the edge when wr_en=1, unless a claim to the same address is accepted in that cycle, in which case busy stays 1 (claim wins).
REQ-018 SHALL accept a write to a non-busy register (no claim required) and leave its busy bit 0.
REQ-019 SHALL update busy_cnt on the same edge as the busy bits: +1 on set only, -1 on clear only, unchanged on set-and-clear or on a net no-op; busy_cnt never exceeds NUM_REGS and never underflows.
REQ-020 SHALL resolve wr_addr==rd_addr1==rd_addr2 by bypassing to both ports.

Reset
REQ-021 SHALL, while reset=1, force all registers to 0, all busy bits to 0 and busy_cnt to 0, independent of clk.
REQ-022 SHALL discard any claim or write presented in a cycle where reset is asserted; the first edge after deassertion behaves normally.

Configuration
REQ-023 SHALL support macro REGFILE_REG0_ZERO_EN; when defined, register 0 reads as 0 (no bypass), writes to it are ignored, claims to it give claim_ok=claim_en without setting busy, and rd_busy for address 0 is 0.
REQ-024 SHALL, without REGFILE_REG0_ZERO_EN, treat register 0 like every other register.

Structure
REQ-025 SHALL place default DATA_W/ADDR_W constants and the register-address type in shared package regfile_pkg.
REQ-026 SHALL implement busy bits and busy_cnt in sub-module busy_tracker; storage and bypass stay in the top.

Verification
REQ-027 SHALL check: reset mid-run after writing r3=0x5A and claiming r5 -> rd_data(r3)=0x00, rd_busy(r5)=0, busy_cnt=0.
REQ-028 SHALL check: wr_en=1, wr_addr=2, wr_data=0xC3, rd_addr1=2 in the same cycle -> rd_data1=0xC3 combinationally, stored 0xC3 after the edge.
REQ-029 SHALL check: claim r4 accepted, then claim r4 again -> second claim_ok=0, busy_cnt stays 1; write r4=0x11 -> busy cleared, busy_cnt=0.
REQ-030 SHALL check: r6 busy, same-cycle write r6=0x7E plus claim r6 -> claim_ok=1, busy[6] stays 1, busy_cnt unchanged, rd_data(r6)=0x7E.
REQ-031 SHALL check: claim all 8 registers with DATA_W=8, ADDR_W=3 -> busy_cnt=8; claim r0 again -> claim_ok=0 (1 with REGFILE_REG0_ZERO_EN and busy_cnt=7).
REQ-032 SHALL check: with REGFILE_REG0_ZERO_EN, write r0=0xFF -> rd_data(r0)=0x00 in the same cycle and after the edge.
